// File: rtl/pipelined_reduce_gate.sv
// Bubble-masked bit reduction (OR/AND/XOR/XNOR) with a valid-tagged pipeline,
// optional sticky capture and a change pulse, for flag/interrupt aggregation.
module pipelined_reduce_gate #(
  parameter int unsigned             NrOfInputs  = 7,
  parameter logic [NrOfInputs-1:0]   BubblesMask = '0,
  parameter int unsigned             PipeStages  = 1
) (
  input  logic                  GlobalClock,
  input  logic                  Reset_n,
  input  logic                  ClockEnable,
  input  logic [NrOfInputs-1:0] Inputs,
  input  logic                  InValid,
  input  logic [1:0]            Mode,
  input  logic                  Sticky,
  input  logic                  Clear,
  output logic                  Result,
  output logic                  OutValid,
  output logic                  Changed
);

  typedef enum logic [1:0] {
    MODE_OR   = 2'b00,
    MODE_AND  = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_XNOR = 2'b11
  } mode_e;

  if ((NrOfInputs < 2) || (NrOfInputs > 64)) begin : g_bad_inputs
    $error("pipelined_reduce_gate: NrOfInputs must be 2..64");
  end
  if ((PipeStages < 1) || (PipeStages > 4)) begin : g_bad_stages
    $error("pipelined_reduce_gate: PipeStages must be 1..4");
  end

  logic [NrOfInputs-1:0] real_c;
  logic                  red_c;
  logic                  last_data;
  logic                  last_valid;

  // Stage 0: bubble inversion and run-time selected reduction
  always_comb begin
    real_c = Inputs ^ BubblesMask;
    red_c  = 1'b0;
    unique case (mode_e'(Mode))
      MODE_OR:   red_c = |real_c;
      MODE_AND:  red_c = &real_c;
      MODE_XOR:  red_c = ^real_c;
      MODE_XNOR: red_c = ~^real_c;
      default:   red_c = 1'b0;
    endcase
  end

  // The Result register is the final stage, so PipeStages-1 intermediate stages sit in front of it
  if (PipeStages == 1) begin : g_direct
    assign last_data  = red_c;
    assign last_valid = InValid;
  end else begin : g_pipe
    localparam int unsigned Depth = PipeStages - 1;
    logic [Depth-1:0] data_q;
    logic [Depth-1:0] vld_q;

    always_ff @(posedge GlobalClock or negedge Reset_n) begin
      if (!Reset_n) begin
        data_q <= '0;
        vld_q  <= '0;
      end else if (ClockEnable) begin
        data_q[0] <= red_c;
        vld_q[0]  <= InValid;
        for (int unsigned i = 1; i < Depth; i++) begin
          data_q[i] <= data_q[i-1];
          vld_q[i]  <= vld_q[i-1];
        end
      end
    end

    assign last_data  = data_q[Depth-1];
    assign last_valid = vld_q[Depth-1];
  end

  logic result_q, result_d;
  logic hold_q, hold_d;
  logic ovalid_q, ovalid_d;
  logic changed_q, changed_d;
  logic set_c;

  // Output stage: sticky hold, result update and change detection
  always_comb begin
    set_c     = last_valid & last_data;
    result_d  = result_q;
    hold_d    = hold_q;
    ovalid_d  = ovalid_q;
    changed_d = 1'b0;
    if (ClockEnable) begin
      ovalid_d = last_valid;
      if (Sticky) begin
        // A set on the same cycle as Clear wins so no event is lost
        hold_d   = Clear ? set_c : (hold_q | set_c);
        result_d = hold_d;
      end else begin
        if (last_valid) begin
          result_d = last_data;
        end
        hold_d = result_d;
      end
      changed_d = (result_d != result_q);
    end
  end

  always_ff @(posedge GlobalClock or negedge Reset_n) begin
    if (!Reset_n) begin
      result_q  <= 1'b0;
      hold_q    <= 1'b0;
      ovalid_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      hold_q    <= hold_d;
      ovalid_q  <= ovalid_d;
      changed_q <= changed_d;
    end
  end

  assign Result   = result_q;
  assign OutValid = ovalid_q;
  // Pulse is suppressed while the block is stalled
  assign Changed  = changed_q & ClockEnable;

endmodule
